// File: rtl/serial_csel_subtractor_pkg.sv
// Shared definitions for the digit-serial carry-select subtractor.
package serial_csel_subtractor_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam int unsigned DIGIT = 2;

endpackage

// File: rtl/serial_csel_subtractor_slice2.sv
// Combinational 2-bit carry-select slice: two ripple pairs (carry-in 0 and 1)
// selected by the real carry.
module csel_sub_slice2 (
    input  logic [1:0] a,
    input  logic [1:0] bn,
    input  logic       cin,
    output logic [1:0] s,
    output logic       c1,
    output logic       cout
);

    logic s0_h0, s1_h0, c1_h0, co_h0;
    logic s0_h1, s1_h1, c1_h1, co_h1;

    always_comb begin
        {c1_h0, s0_h0} = {1'b0, a[0]} + {1'b0, bn[0]};
        {co_h0, s1_h0} = {1'b0, a[1]} + {1'b0, bn[1]} + {1'b0, c1_h0};
        {c1_h1, s0_h1} = {1'b0, a[0]} + {1'b0, bn[0]} + 2'd1;
        {co_h1, s1_h1} = {1'b0, a[1]} + {1'b0, bn[1]} + {1'b0, c1_h1};
    end

    always_comb begin
        s    = cin ? {s1_h1, s0_h1} : {s1_h0, s0_h0};
        c1   = cin ? c1_h1 : c1_h0;
        cout = cin ? co_h1 : co_h0;
    end

endmodule

// File: rtl/serial_csel_subtractor.sv
// Digit-serial two's-complement subtractor, DIFF = A - B, 2 bits per cycle LSB-first.
module serial_csel_subtractor
    import serial_csel_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW,
    output logic             OVF
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH / 2 - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic [1:0]       slice_s;
    logic             slice_c1;
    logic             slice_cout;
    logic [WIDTH-1:0] res_shift;

    csel_sub_slice2 u_slice (
        .a    (op_a_q[1:0]),
        .bn   (op_b_q[1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .c1   (slice_c1),
        .cout (slice_cout)
    );

    always_comb begin
        res_shift = (res_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
    end

    // Results are registered on the edge that processes the last digit, so they
    // are already valid while DONE is high; the slice's c1 on that digit is c_msb.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        res_d    = res_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_RUN: begin
                op_a_d  = op_a_q >> DIGIT;
                op_b_d  = op_b_q >> DIGIT;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                res_d   = res_shift;
                if (cnt_q == LAST_CNT) begin
                    state_d  = S_FIN;
                    done_d   = 1'b1;
                    diff_d   = res_shift;
                    borrow_d = ~slice_cout;
                    ovf_d    = slice_c1 ^ slice_cout;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (START) begin
                    state_d = S_RUN;
                    op_a_d  = A;
                    op_b_d  = ~B;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign DIFF   = diff_q;
    assign BORROW = borrow_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_serial_csel_subtractor.sv
// Directed-vector and random bench for serial_csel_subtractor (WIDTH=8).
module tb_serial_csel_subtractor;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       BUSY, DONE, BORROW, OVF;
    logic [7:0] DIFF;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } vec_t;

    vec_t vecs[9];

    serial_csel_subtractor #(.WIDTH(8)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .A      (A),
        .B      (B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .DIFF   (DIFF),
        .BORROW (BORROW),
        .OVF    (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Caller is #1 after an edge. Returns latency in edges after the accept edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] d, output logic br, output logic ov,
                          output int lat);
        START = 1'b1;
        A = a;
        B = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A = ~a;
        B = a ^ b;
        lat = 0;
        while (!DONE && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        d  = DIFF;
        br = BORROW;
        ov = OVF;
    endtask

    logic [7:0] d;
    logic       br, ov;
    int         lat;
    int         done_seen;
    logic [7:0] ra, rb;
    logic [8:0] ref9;
    logic [7:0] ka, kb;
    logic [7:0] exp_d;

    initial begin
        vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
        vecs[7] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_diff", 32'(DIFF), 32'd0);
        chk("rst_borrow", 32'(BORROW), 32'd0);
        chk("rst_ovf", 32'(OVF), 32'd0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, d, br, ov, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].diff));
            chk($sformatf("vec%0d_borrow", i), 32'(br), 32'(vecs[i].borrow));
            chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ovf));
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_pulse", i), 32'(DONE), 32'd0);
            chk($sformatf("vec%0d_hold", i), 32'(DIFF), 32'(vecs[i].diff));
        end

        // START while busy is ignored
        START = 1'b1;
        A = 8'h5A;
        B = 8'h23;
        @(posedge CLK);
        #1;
        START = 1'b0;
        done_seen = 0;
        d = '0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 2) begin
                START = 1'b1;
                A = 8'hFF;
                B = 8'h00;
            end
            @(posedge CLK);
            #1;
            START = 1'b0;
            if (k == 1) chk("busy_run", 32'(BUSY), 32'd1);
            if (DONE) begin
                done_seen++;
                d = DIFF;
                chk("ign_lat", 32'(k), 32'd4);
            end
        end
        chk("ign_done_count", 32'(done_seen), 32'd1);
        chk("ign_diff", 32'(d), 32'h37);

        // START held high: accepts at edges 0,5,10
        START = 1'b1;
        for (int k = 0; k < 15; k++) begin
            A = 8'(k * 17 + 9);
            B = 8'(k * 5 + 3);
            @(posedge CLK);
            #1;
            if (k == 14) START = 1'b0;
            chk($sformatf("hold_done%0d", k), 32'(DONE), 32'((k % 5) == 4));
            if ((k % 5) == 4) begin
                ka = 8'((k - 4) * 17 + 9);
                kb = 8'((k - 4) * 5 + 3);
                exp_d = ka - kb;
                chk($sformatf("hold_diff%0d", k), 32'(DIFF), 32'(exp_d));
            end
        end
        @(posedge CLK);
        #1;

        // Reset mid-op aborts
        START = 1'b1;
        A = 8'h33;
        B = 8'h11;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_diff", 32'(DIFF), 32'd0);
        chk("abort_borrow", 32'(BORROW), 32'd0);
        chk("abort_ovf", 32'(OVF), 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK);
            #1;
            if (DONE) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        run_op(8'h33, 8'h11, d, br, ov, lat);
        chk("post_rst_lat", 32'(lat), 32'd4);
        chk("post_rst_diff", 32'(d), 32'h22);

        // Random operands against an arithmetic reference
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ref9 = {1'b0, ra} - {1'b0, rb};
            run_op(ra, rb, d, br, ov, lat);
            chk("rnd_lat", 32'(lat), 32'd4);
            chk("rnd_diff", 32'(d), 32'(ref9[7:0]));
            chk("rnd_borrow", 32'(br), 32'(ref9[8]));
            chk("rnd_ovf", 32'(ov), 32'((ra[7] != rb[7]) && (ref9[7] != ra[7])));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
